stack_exec_unit: RTL
====================

Name: stack_exec_unit

Overview:
- Operand stack plus execute sequencer sitting directly upstream of the stack-machine ALU.
- Accepts one instruction (opcode + optional immediate), pops the needed operands from an internal LIFO, and drives them onto the combinational ALU's operando1/operando2/opcode inputs.
- Captures the ALU's resultado or data_uc, pushes the 16-bit result back, and reports completion and condition to the control unit.

Parameters:
- DATA_W, 16, operand/stack word width (matches ALU operand width).
- DEPTH, 16, number of stack entries.
- PTR_W, 5, pointer/count width; must hold 0..DEPTH inclusive.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  instruction valid; sampled only in IDLE.
- opcode  in  5  instruction opcode; ALU encoding plus Pop = 5'b00011.
- imm  in  DATA_W  immediate for Push.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at instruction end.
- cond_flag  out  1  registered data_uc of the last If_* instruction.
- underflow_err  out  1  sticky until next accepted start.
- overflow_err  out  1  sticky until next accepted start.
- illegal_op  out  1  sticky until next accepted start.
- top  out  DATA_W  mem[sp-1]; 0 when empty.
- depth  out  PTR_W  current entry count (sp).
- alu_op1  out  DATA_W  to ALU operando1.
- alu_op2  out  DATA_W  to ALU operando2.
- alu_opcode  out  5  to ALU opcode.
- alu_result  in  32  from ALU resultado.
- alu_cond  in  1  from ALU data_uc.

Behaviour:
- Reset, asynchronous on reset_n low:
  - sp = 0, FSM = IDLE.
  - All outputs 0; alu_op1/alu_op2/alu_opcode registers cleared.
  - Reset mid-instruction aborts it: no done, no partial push.
- Opcode classes:
  - BIN (00100..01100: Add, Sub, Mul, Div, And, Nand, Or, Xor, Cmp): needs 2, pushes 1.
  - UN (Not 01101): needs 1, pushes 1.
  - COND (01111..10011): needs 1, pushes 0.
  - PUSH (00010): needs 0, pushes 1.
  - POP (00011): needs 1, pushes 0.
  - All other opcodes are illegal.
- FSM states: IDLE, POP_B, POP_A, EXEC, WRITE, DONE. Exactly one state per clock.
- IDLE:
  - start=1 latches opcode/imm and clears the three error flags.
  - Illegal opcode: set illegal_op, go to DONE.
  - depth < needed operands: set underflow_err, go to DONE; stack untouched.
  - PUSH with depth == DEPTH: set overflow_err, go to DONE.
  - Otherwise:
    - BIN/UN/COND/POP go to POP_B.
    - PUSH loads alu_op1 = imm and goes to EXEC.
- POP_B: alu_op2 <= top (BIN) or alu_op1 <= top (UN/COND/POP); sp--.
  - BIN goes to POP_A.
  - POP goes to DONE.
  - UN/COND go to EXEC.
- POP_A: alu_op1 <= top; sp--; go to EXEC. First-pushed operand is operando1 (A op B).
- EXEC:
  - alu_opcode is held stable for this whole cycle; the ALU is combinational.
  - Register result_q <= alu_result[15:0], truncated (upper 16 bits discarded, including Mul high half).
  - COND: cond_flag <= alu_cond, go to DONE; else go to WRITE.
- WRITE: mem[sp] <= result_q; sp++; go to DONE.
- DONE: done = 1 for exactly this cycle; go to IDLE.
- start while busy is ignored; no queuing.
- Latency, cycles from accepting edge to done-high cycle inclusive:
  - BIN 5, UN 4, COND 3, PUSH 3, POP 2.
  - Error/illegal 1 (DONE only).
- Boundaries:
  - BIN never overflows (net -1).
  - UN never overflows (net 0).
  - Div by zero: push whatever alu_result[15:0] the ALU returns; no error.
  - Cmp less-than result -1 is pushed as 16'hFFFF.
- cond_flag holds its value until the next COND completes or reset.
- Error flags assert in the DONE cycle at the latest.

Decomposition:
- Shared package holds:
  - Opcode localparams, shared with the ALU: OP_PUSH, OP_POP, OP_ADD..OP_IF_LE.
  - FSM state encoding.
  - Opcode-class helper function, returning needed-operand count and push flag.
- One sub-module, stack_mem:
  - DEPTH x DATA_W register array, one synchronous write port, combinational read of mem[sp-1].
  - Owns sp with inc/dec controls.

Test Plan:
- PUSH 5, PUSH 3, Sub -> alu_op1=5, alu_op2=3 in EXEC; top=2, depth=1; done 5 cycles after Sub start.
- PUSH 3, PUSH 7, Cmp -> top=16'hFFFF, depth=1. Then PUSH 0, If_eq -> cond_flag=1, depth=1, top=16'hFFFF.
- From empty: PUSH 9, Add -> underflow_err=1, depth=1, top=9, done after 1 cycle. Next legal start clears underflow_err.
- 16 PUSHes of values 1..16 -> depth=16, top=16. 17th PUSH -> overflow_err=1, depth stays 16.
- PUSH 300, PUSH 300, Mul -> top=16'h5F90 (90000 truncated), depth=1.
- Start Add, drop reset_n in POP_A -> no done; depth=0, busy=0, all outputs 0 immediately (asynchronous). Start pulsed during busy -> ignored, depth change matches a single instruction.

Source files
------------

// File: rtl/stack_exec_unit_pkg.sv
// rtl/stack_exec_unit_pkg.sv - opcodes, FSM states and opcode-class decode shared by the stack exec unit
package stack_exec_unit_pkg;

    // Opcode encoding shared with the stack-machine ALU
    localparam logic [4:0] OP_PUSH  = 5'b00010;
    localparam logic [4:0] OP_POP   = 5'b00011;
    localparam logic [4:0] OP_ADD   = 5'b00100;
    localparam logic [4:0] OP_SUB   = 5'b00101;
    localparam logic [4:0] OP_MUL   = 5'b00110;
    localparam logic [4:0] OP_DIV   = 5'b00111;
    localparam logic [4:0] OP_AND   = 5'b01000;
    localparam logic [4:0] OP_NAND  = 5'b01001;
    localparam logic [4:0] OP_OR    = 5'b01010;
    localparam logic [4:0] OP_XOR   = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_NOT   = 5'b01101;
    localparam logic [4:0] OP_IF_EQ = 5'b01111;
    localparam logic [4:0] OP_IF_NE = 5'b10000;
    localparam logic [4:0] OP_IF_LT = 5'b10001;
    localparam logic [4:0] OP_IF_GT = 5'b10010;
    localparam logic [4:0] OP_IF_LE = 5'b10011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP_B,
        ST_POP_A,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILL,
        CLS_BIN,
        CLS_UN,
        CLS_COND,
        CLS_PUSH,
        CLS_POP
    } op_cls_t;

    typedef struct packed {
        op_cls_t    cls;
        logic [1:0] needs;   // operands popped before execution
        logic       pushes;  // result written back to the stack
    } op_info_t;

    function automatic op_info_t decode_op(input logic [4:0] op);
        op_info_t info;
        info.cls    = CLS_ILL;
        info.needs  = 2'd0;
        info.pushes = 1'b0;
        if (op >= OP_ADD && op <= OP_CMP) begin
            info.cls    = CLS_BIN;
            info.needs  = 2'd2;
            info.pushes = 1'b1;
        end else if (op == OP_NOT) begin
            info.cls    = CLS_UN;
            info.needs  = 2'd1;
            info.pushes = 1'b1;
        end else if (op >= OP_IF_EQ && op <= OP_IF_LE) begin
            info.cls    = CLS_COND;
            info.needs  = 2'd1;
        end else if (op == OP_PUSH) begin
            info.cls    = CLS_PUSH;
            info.pushes = 1'b1;
        end else if (op == OP_POP) begin
            info.cls    = CLS_POP;
            info.needs  = 2'd1;
        end
        return info;
    endfunction

endpackage

// File: rtl/stack_exec_unit_stack_mem.sv
// rtl/stack_exec_unit_stack_mem.sv - LIFO register array with stack pointer
// Ports: clock/reset_n (async active-low), push writes wdata at mem[sp] and
// increments sp, pop decrements sp, top = mem[sp-1] (0 when empty), sp = count.
module stack_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] top,
    output logic [PTR_W-1:0]  sp
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;

    assign wr_idx = AW'(sp);
    assign rd_idx = AW'(sp - 1'b1);

    // Contents need no reset: sp == 0 masks them from top.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_idx] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + 1'b1;
        end else if (pop) begin
            sp <= sp - 1'b1;
        end
    end

    assign top = (sp == '0) ? '0 : mem[rd_idx];

endmodule

// File: rtl/stack_exec_unit.sv
// rtl/stack_exec_unit.sv - operand stack and execute sequencer feeding a combinational ALU
// Ports: clock/reset_n (async active-low); start/opcode/imm instruction in;
// busy/done/cond_flag and sticky underflow_err/overflow_err/illegal_op status;
// top/depth stack view; alu_op1/alu_op2/alu_opcode to ALU, alu_result/alu_cond back.
module stack_exec_unit
    import stack_exec_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [4:0]        opcode,
    input  logic [DATA_W-1:0] imm,
    output logic              busy,
    output logic              done,
    output logic              cond_flag,
    output logic              underflow_err,
    output logic              overflow_err,
    output logic              illegal_op,
    output logic [DATA_W-1:0] top,
    output logic [PTR_W-1:0]  depth,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [4:0]        alu_opcode,
    input  logic [31:0]       alu_result,
    input  logic              alu_cond
);
    localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);

    state_t            state;
    op_cls_t           cls_q;
    logic              pushes_q;
    logic [DATA_W-1:0] result_q;
    op_info_t          info;
    logic              mem_push;
    logic              mem_pop;
    logic              unused_hi;

    // Results are word-sized; the ALU's upper half (e.g. Mul high) is dropped.
    assign unused_hi = ^alu_result[31:DATA_W];

    assign info     = decode_op(opcode);
    assign mem_pop  = (state == ST_POP_B) || (state == ST_POP_A);
    assign mem_push = (state == ST_WRITE);

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_stack (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (mem_push),
        .pop     (mem_pop),
        .wdata   (result_q),
        .top     (top),
        .sp      (depth)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cls_q         <= CLS_ILL;
            pushes_q      <= 1'b0;
            result_q      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cond_flag     <= 1'b0;
            underflow_err <= 1'b0;
            overflow_err  <= 1'b0;
            illegal_op    <= 1'b0;
            alu_op1       <= '0;
            alu_op2       <= '0;
            alu_opcode    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cls_q         <= info.cls;
                        pushes_q      <= info.pushes;
                        busy          <= 1'b1;
                        underflow_err <= 1'b0;
                        overflow_err  <= 1'b0;
                        illegal_op    <= 1'b0;
                        if (info.cls == CLS_ILL) begin
                            illegal_op <= 1'b1;
                            done       <= 1'b1;
                            state      <= ST_DONE;
                        end else if (depth < PTR_W'(info.needs)) begin
                            underflow_err <= 1'b1;
                            done          <= 1'b1;
                            state         <= ST_DONE;
                        end else if (info.cls == CLS_PUSH && depth == FULL) begin
                            overflow_err <= 1'b1;
                            done         <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            alu_opcode <= opcode;
                            if (info.cls == CLS_PUSH) begin
                                alu_op1 <= imm;
                                state   <= ST_EXEC;
                            end else begin
                                state <= ST_POP_B;
                            end
                        end
                    end
                end
                ST_POP_B: begin
                    // B is the most recently pushed operand, so it goes to op2.
                    if (cls_q == CLS_BIN) begin
                        alu_op2 <= top;
                        state   <= ST_POP_A;
                    end else begin
                        alu_op1 <= top;
                        if (cls_q == CLS_POP) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_POP_A: begin
                    alu_op1 <= top;
                    state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Push bypasses the ALU: the immediate is the result.
                    result_q <= (cls_q == CLS_PUSH) ? alu_op1 : alu_result[DATA_W-1:0];
                    if (pushes_q) begin
                        state <= ST_WRITE;
                    end else begin
                        cond_flag <= alu_cond;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
